// File: rtl/count_to_mask_gen_pkg.sv
// Shared width derivation for the count-to-mask generator and the leading zero/one counter,
// so count and index widths always agree between the two blocks.
package count_to_mask_gen_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  // Count range is 0..DATA_WIDTH inclusive, hence one bit more than the index width.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

  function automatic int head_width(input int data_width);
    return $clog2(data_width);
  endfunction

endpackage

// File: rtl/count_to_mask_gen_mask_rotate.sv
// Combinational barrel rotate-left: one stage per amount bit, stage s rotates by 2**s.
module mask_rotate #(
  parameter int DATA_WIDTH = 16,
  parameter int HEAD_W     = 4
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [HEAD_W-1:0]     i_amt,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_stage [HEAD_W+1];

  assign w_stage[0] = i_data;

  for (genvar s = 0; s < HEAD_W; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign w_stage[s+1] = i_amt[s]
      ? {w_stage[s][DATA_WIDTH-SH-1:0], w_stage[s][DATA_WIDTH-1 -: SH]}
      : w_stage[s];
  end

  assign o_data = w_stage[HEAD_W];

endmodule

// File: rtl/count_to_mask_gen.sv
// Builds a wrapping contiguous run mask from (count, head): S1 registers a thermometer of
// count bits plus the head, S2 registers the rotated, polarity-adjusted mask.
module count_to_mask_gen
  import count_to_mask_gen_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  FILL_ONE   = 1,
  localparam int CNT_W      = cnt_width(DATA_WIDTH),
  localparam int HEAD_W     = head_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CNT_W-1:0]      in_cnt,
  input  logic [HEAD_W-1:0]     in_head,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_mask
);

  localparam logic [DATA_WIDTH-1:0] MASK_IDLE = (FILL_ONE != 0) ? '0 : '1;

  // Thermometer from bit 0: each count bit i appends 2**i ones; the top count bit means
  // count >= DATA_WIDTH and saturates to all ones.
  function automatic logic [DATA_WIDTH-1:0] sat_therm(input logic [CNT_W-1:0] cnt);
    logic [DATA_WIDTH-1:0] t;
    t = '0;
    for (int i = 0; i < HEAD_W; i++) begin
      if (cnt[i]) t = (t << (1 << i)) | ~({DATA_WIDTH{1'b1}} << (1 << i));
    end
    if (cnt[CNT_W-1]) t = '1;
    return t;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] apply_fill(input logic [DATA_WIDTH-1:0] run);
    return (FILL_ONE != 0) ? run : ~run;
  endfunction

  logic [DATA_WIDTH-1:0] r_therm_p1;
  logic [HEAD_W-1:0]     r_head_p1;
  logic                  r_vld_p1;
  logic [DATA_WIDTH-1:0] r_mask_p2;
  logic                  r_vld_p2;

  logic                  w_s2_load;
  logic                  w_s1_adv;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_rot_p1;

  assign w_s2_load = !r_vld_p2 || out_ready;
  assign w_s1_adv  = r_vld_p1 && w_s2_load;
  assign in_ready  = rst_n && !flush && (!r_vld_p1 || w_s1_adv);
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_accept)      r_vld_p1 <= 1'b1;
      else if (w_s1_adv) r_vld_p1 <= 1'b0;
      if (w_s2_load)     r_vld_p2 <= r_vld_p1;
    end
  end

  // Stage S1: thermometer and head capture
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_therm_p1 <= sat_therm(in_cnt);
      r_head_p1  <= in_head;
    end
  end

  mask_rotate #(
    .DATA_WIDTH (DATA_WIDTH),
    .HEAD_W     (HEAD_W)
  ) u_mask_rotate (
    .i_data (r_therm_p1),
    .i_amt  (r_head_p1),
    .o_data (w_rot_p1)
  );

  // Stage S2: rotated mask; holds its value across stalls and flush
  always_ff @(posedge clk) begin
    if (!rst_n)                   r_mask_p2 <= MASK_IDLE;
    else if (!flush && w_s1_adv)  r_mask_p2 <= apply_fill(w_rot_p1);
  end

  assign out_valid = r_vld_p2;
  assign out_mask  = r_mask_p2;

endmodule
